ascon_sequencer: RTL and testbench
==================================

Name: ascon_sequencer

Overview:
- Control FSM that sequences one Ascon AEAD operation over a shared permutation engine and state datapath: load, init, AD absorb, domain separation, data absorb/squeeze, finalization, tag.
- Issues single-cycle command strobes to the state datapath and a start/done handshake to the permutation unit.
- Holds no cipher data. Sits between the serial input front-end and the core datapath.

Parameters:
- A, 12, rounds for initialization and finalization permutations
- B, 6, rounds for intermediate permutations
- AD_BLOCKS, 1, number of r-bit associated-data blocks after padding; 0 = no AD
- PT_BLOCKS, 1, number of r-bit plaintext/ciphertext blocks after padding; must be >= 1
- CW, 8, width of block counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation; honoured only in IDLE
- decrypt  in  1  mode, sampled with accepted start
- abort  in  1  synchronous abort; returns FSM to IDLE
- perm_done  in  1  one-cycle pulse from permutation unit
- perm_start  out  1  one-cycle pulse launching the permutation
- perm_rounds  out  4  round count, valid while perm_start=1
- ld_state  out  1  load IV||K||N into state
- init_key_xor  out  1  XOR 0*||K into state after init
- ad_absorb  out  1  XOR AD block blk_idx into rate
- dom_sep  out  1  XOR 1 into state LSB
- data_absorb  out  1  XOR/replace data block blk_idx (per dec_mode)
- final_key_xor  out  1  XOR K into capacity before final permutation
- tag_xor  out  1  form tag = state tail XOR K
- blk_idx  out  CW  current block index
- dec_mode  out  1  latched decrypt
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, same cycle as tag_xor
- aborted  out  1  one-cycle pulse after abort accepted

Behaviour:
- Reset: FSM=IDLE; all outputs 0; counters 0. Reset mid-operation wins over everything and takes effect at the next edge. Pending perm_done after reset is ignored.
- States: IDLE, LOAD, INIT_P, INIT_K, AD_ABS, AD_P, DSEP, DAT_ABS, DAT_P, FIN_K, FIN_P, TAG.
- IDLE: start=1 -> LOAD; latch dec_mode; blk_idx=0.
- Start accepted at edge t: ld_state=1 in cycle t+1; perm_start=1 with perm_rounds=A in cycle t+2.
- LOAD (ld_state, 1 cycle) -> INIT_P.
- INIT_P: wait for perm_done -> INIT_K.
- INIT_K (init_key_xor, 1 cycle) -> AD_ABS if AD_BLOCKS>0, else DSEP.
- AD_ABS (ad_absorb, 1 cycle) -> AD_P with rounds B.
- AD_P: on perm_done, blk_idx+1. If blk_idx was AD_BLOCKS-1: blk_idx=0 -> DSEP; else -> AD_ABS.
- DSEP (dom_sep, 1 cycle) -> DAT_ABS.
- DAT_ABS (data_absorb, 1 cycle): if blk_idx=PT_BLOCKS-1 -> FIN_K (last block is never permuted with B); else -> DAT_P with rounds B.
- DAT_P: on perm_done, blk_idx+1 -> DAT_ABS.
- FIN_K (final_key_xor, 1 cycle) -> FIN_P with rounds A.
- FIN_P: on perm_done -> TAG.
- TAG (tag_xor and done, 1 cycle) -> IDLE; busy drops next cycle.
- Permutation handshake:
  - perm_start is high exactly in the first cycle of each *_P state.
  - perm_done is accepted only from the cycle after perm_start onward.
  - perm_done coincident with perm_start, or outside *_P states, is ignored.
  - Permutation latency is unbounded; no timeout.
- Command strobes are mutually exclusive; at most one high per cycle.
- start while busy: ignored, no queueing.
- start in the same cycle as done (TAG): ignored; a new start is needed in IDLE.
- abort: in any non-IDLE state -> IDLE next edge; aborted=1 for one cycle; no other strobe in that cycle. Abort in IDLE is a no-op. Abort and start together in IDLE: abort wins, nothing starts.
- Permutation count per operation = 2 + AD_BLOCKS + (PT_BLOCKS-1).
- blk_idx never exceeds max(AD_BLOCKS, PT_BLOCKS)-1. Counter width CW must cover this; assertion if not.

Decomposition:
- Package ascon_pkg: state enum, default round constants (A=12, B=6), IV constant shared with the datapath.
- Sub-module ascon_perm_handshake: perm_start pulse generation, done qualification.

Test Plan:
- AD_BLOCKS=2, PT_BLOCKS=3, perm model latency 3 -> 6 perm_start pulses, rounds 12,6,6,6,6,12; strobe order ld, init_key, ad0, ad1, dom_sep, dat0, dat1, dat2, final_key, tag; done once; busy=0 next cycle.
- AD_BLOCKS=0, PT_BLOCKS=1 -> rounds 12,12 only; dom_sep directly follows init_key_xor; no ad_absorb.
- perm_done driven in the perm_start cycle and in AD_ABS -> ignored; FSM advances only on a qualified done.
- abort during AD_P with blk_idx=1 -> aborted pulse, IDLE, busy=0; next start runs the full sequence from blk_idx=0.
- rst asserted in DAT_P, then a stale perm_done -> all outputs 0, FSM stays IDLE.
- start pulsed while busy and in the TAG cycle, with decrypt=1 -> ignored; dec_mode keeps its original value; one done per accepted start.

Source files
------------

// File: rtl/ascon_sequencer_pkg.sv
// Shared definitions for the Ascon AEAD control slice.
//   state_t        : sequencer FSM states
//   ROUNDS_A/B     : default permutation round counts (init/final, intermediate)
//   ASCON128_IV    : initialization vector loaded by the state datapath
//   is_perm_state  : true for states that wait on the permutation engine
package ascon_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT_P,
        ST_INIT_K,
        ST_AD_ABS,
        ST_AD_P,
        ST_DSEP,
        ST_DAT_ABS,
        ST_DAT_P,
        ST_FIN_K,
        ST_FIN_P,
        ST_TAG
    } state_t;

    localparam int unsigned ROUNDS_A = 12;
    localparam int unsigned ROUNDS_B = 6;

    localparam logic [63:0] ASCON128_IV = 64'h8040_0c06_0000_0000;

    function automatic logic is_perm_state(input state_t s);
        return (s == ST_INIT_P) || (s == ST_AD_P) || (s == ST_DAT_P) || (s == ST_FIN_P);
    endfunction

endpackage

// File: rtl/ascon_sequencer_perm_handshake.sv
// Start/done handshake towards the permutation unit.
//   clk, rst   : clock, synchronous active-high reset
//   launch     : FSM is entering a permutation-wait state this cycle
//   in_perm    : FSM is currently in a permutation-wait state
//   perm_done  : raw completion pulse from the permutation unit
//   perm_start : one-cycle launch pulse, first cycle of the wait state
//   done_ok    : qualified completion, accepted by the FSM
module ascon_perm_handshake (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    input  logic in_perm,
    input  logic perm_done,
    output logic perm_start,
    output logic done_ok
);

    // armed goes high the cycle after perm_start, so a done that coincides
    // with the launch pulse (or arrives outside a wait state) is dropped.
    logic armed;

    assign done_ok = perm_done && armed && in_perm;

    always_ff @(posedge clk) begin
        if (rst) begin
            perm_start <= 1'b0;
            armed      <= 1'b0;
        end else begin
            perm_start <= launch;
            if (perm_start) begin
                armed <= 1'b1;
            end else if (!in_perm || done_ok) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ascon_sequencer.sv
// Control FSM sequencing one Ascon AEAD operation over a shared permutation
// engine. Holds no cipher data; drives single-cycle command strobes to the
// state datapath.
//   clk, rst                 : clock, synchronous active-high reset
//   start, decrypt           : operation request (IDLE only) and its mode
//   abort                    : return to IDLE from any busy state
//   perm_done                : completion pulse from the permutation unit
//   perm_start, perm_rounds  : permutation launch pulse and its round count
//   ld_state .. tag_xor      : mutually exclusive datapath command strobes
//   blk_idx, dec_mode        : current block index and latched mode
//   busy, done, aborted      : status
module ascon_sequencer
    import ascon_pkg::*;
#(
    parameter int unsigned A         = ROUNDS_A,
    parameter int unsigned B         = ROUNDS_B,
    parameter int unsigned AD_BLOCKS = 1,
    parameter int unsigned PT_BLOCKS = 1,
    parameter int unsigned CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          decrypt,
    input  logic          abort,
    input  logic          perm_done,
    output logic          perm_start,
    output logic [3:0]    perm_rounds,
    output logic          ld_state,
    output logic          init_key_xor,
    output logic          ad_absorb,
    output logic          dom_sep,
    output logic          data_absorb,
    output logic          final_key_xor,
    output logic          tag_xor,
    output logic [CW-1:0] blk_idx,
    output logic          dec_mode,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    localparam int unsigned MAX_BLK = (AD_BLOCKS > PT_BLOCKS) ? AD_BLOCKS : PT_BLOCKS;
    localparam bit CFG_OK = (PT_BLOCKS >= 1) && (A < 16) && (B < 16) &&
                            ((CW >= 32) || ((MAX_BLK - 1) < (64'd1 << CW)));

    localparam logic [CW-1:0] AD_LAST = CW'((AD_BLOCKS > 0) ? AD_BLOCKS - 1 : 0);
    localparam logic [CW-1:0] PT_LAST = CW'((PT_BLOCKS > 0) ? PT_BLOCKS - 1 : 0);

    state_t        state, state_next;
    logic [CW-1:0] blk_next;
    logic          dec_next;
    logic          launch;
    logic          perm_ok;

    // Entering a wait state from a non-wait state launches the permutation;
    // the handshake registers it so perm_start lines up with that state's first cycle.
    assign launch = is_perm_state(state_next) && !is_perm_state(state);

    ascon_perm_handshake u_hs (
        .clk        (clk),
        .rst        (rst),
        .launch     (launch),
        .in_perm    (is_perm_state(state)),
        .perm_done  (perm_done),
        .perm_start (perm_start),
        .done_ok    (perm_ok)
    );

    always_comb begin
        perm_rounds = '0;
        if (perm_start) begin
            perm_rounds = ((state == ST_INIT_P) || (state == ST_FIN_P)) ? 4'(A) : 4'(B);
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_next    = state;
        blk_next      = blk_idx;
        dec_next      = dec_mode;
        ld_state      = 1'b0;
        init_key_xor  = 1'b0;
        ad_absorb     = 1'b0;
        dom_sep       = 1'b0;
        data_absorb   = 1'b0;
        final_key_xor = 1'b0;
        tag_xor       = 1'b0;
        done          = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_LOAD;
                    dec_next   = decrypt;
                    blk_next   = '0;
                end
            end
            ST_LOAD: begin
                ld_state   = 1'b1;
                state_next = ST_INIT_P;
            end
            ST_INIT_P: begin
                if (perm_ok) state_next = ST_INIT_K;
            end
            ST_INIT_K: begin
                init_key_xor = 1'b1;
                state_next   = (AD_BLOCKS > 0) ? ST_AD_ABS : ST_DSEP;
            end
            ST_AD_ABS: begin
                ad_absorb  = 1'b1;
                state_next = ST_AD_P;
            end
            ST_AD_P: begin
                if (perm_ok) begin
                    if (blk_idx == AD_LAST) begin
                        blk_next   = '0;
                        state_next = ST_DSEP;
                    end else begin
                        blk_next   = blk_idx + CW'(1);
                        state_next = ST_AD_ABS;
                    end
                end
            end
            ST_DSEP: begin
                dom_sep    = 1'b1;
                state_next = ST_DAT_ABS;
            end
            ST_DAT_ABS: begin
                data_absorb = 1'b1;
                // The last data block goes straight to finalization.
                state_next  = (blk_idx == PT_LAST) ? ST_FIN_K : ST_DAT_P;
            end
            ST_DAT_P: begin
                if (perm_ok) begin
                    blk_next   = blk_idx + CW'(1);
                    state_next = ST_DAT_ABS;
                end
            end
            ST_FIN_K: begin
                final_key_xor = 1'b1;
                state_next    = ST_FIN_P;
            end
            ST_FIN_P: begin
                if (perm_ok) state_next = ST_TAG;
            end
            ST_TAG: begin
                tag_xor    = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            blk_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            blk_idx  <= '0;
            dec_mode <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state    <= state_next;
            blk_idx  <= blk_next;
            dec_mode <= dec_next;
            aborted  <= abort && (state != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (CFG_OK);
            assert ($onehot0({ld_state, init_key_xor, ad_absorb, dom_sep,
                              data_absorb, final_key_xor, tag_xor}));
        end
    end

endmodule

// File: tb/tb_ascon_sequencer.sv
module tb_ascon_sequencer;

    localparam int unsigned EV_LD = 100;
    localparam int unsigned EV_IK = 200;
    localparam int unsigned EV_AD = 300;
    localparam int unsigned EV_DS = 400;
    localparam int unsigned EV_DA = 500;
    localparam int unsigned EV_FK = 600;
    localparam int unsigned EV_TG = 700;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, decrypt, abort, stale, pd, sel, inj;
    logic perm_done;
    int unsigned cyc = 0;
    int unsigned done_cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned cnt = 0;
    int unsigned lat_min, lat_max;
    logic exp_dec;
    logic after_perm = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned obs_ev[$], exp_ev[$], obs_rounds[$], exp_rounds[$];

    // DUT a: AD_BLOCKS=2, PT_BLOCKS=3; DUT b: AD_BLOCKS=0, PT_BLOCKS=1
    logic       a_ps, a_ld, a_ik, a_ad, a_ds, a_da, a_fk, a_tx, a_dec, a_busy, a_done, a_ab;
    logic [3:0] a_rounds;
    logic [7:0] a_blk;
    logic       b_ps, b_ld, b_ik, b_ad, b_ds, b_da, b_fk, b_tx, b_dec, b_busy, b_done, b_ab;
    logic [3:0] b_rounds;
    logic [7:0] b_blk;

    assign perm_done = pd | stale;

    ascon_sequencer #(.A(12), .B(6), .AD_BLOCKS(2), .PT_BLOCKS(3), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .decrypt(decrypt), .abort(abort & ~sel),
        .perm_done(perm_done & ~sel), .perm_start(a_ps), .perm_rounds(a_rounds),
        .ld_state(a_ld), .init_key_xor(a_ik), .ad_absorb(a_ad), .dom_sep(a_ds),
        .data_absorb(a_da), .final_key_xor(a_fk), .tag_xor(a_tx), .blk_idx(a_blk),
        .dec_mode(a_dec), .busy(a_busy), .done(a_done), .aborted(a_ab)
    );

    ascon_sequencer #(.A(12), .B(6), .AD_BLOCKS(0), .PT_BLOCKS(1), .CW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .decrypt(decrypt), .abort(abort & sel),
        .perm_done(perm_done & sel), .perm_start(b_ps), .perm_rounds(b_rounds),
        .ld_state(b_ld), .init_key_xor(b_ik), .ad_absorb(b_ad), .dom_sep(b_ds),
        .data_absorb(b_da), .final_key_xor(b_fk), .tag_xor(b_tx), .blk_idx(b_blk),
        .dec_mode(b_dec), .busy(b_busy), .done(b_done), .aborted(b_ab)
    );

    logic [23:0] a_vec, b_vec, m_vec;
    logic        m_ps, m_dec, m_busy, m_done, m_ab;
    logic [3:0]  m_rounds;
    logic [6:0]  m_cmd;
    logic [7:0]  m_blk;

    assign a_vec = {a_ps, a_rounds, a_ld, a_ik, a_ad, a_ds, a_da, a_fk, a_tx, a_blk, a_dec, a_busy, a_done, a_ab};
    assign b_vec = {b_ps, b_rounds, b_ld, b_ik, b_ad, b_ds, b_da, b_fk, b_tx, b_blk, b_dec, b_busy, b_done, b_ab};
    assign m_vec = sel ? b_vec : a_vec;
    assign {m_ps, m_rounds, m_cmd, m_blk, m_dec, m_busy, m_done, m_ab} = m_vec;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Permutation unit model: done after a random latency, optional spurious pulses
    always @(negedge clk) begin
        pd = 1'b0;
        if (rst) begin
            cnt = 0;
        end else begin
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    pd = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (m_ps) begin
                cnt = $urandom_range(lat_max, lat_min);
                if (inj) pd = 1'b1;
            end
            if (inj && m_cmd[4]) pd = 1'b1;
        end
    end

    // Monitor: records command/permutation activity and checks per-cycle rules
    always @(negedge clk) begin
        if (rst) begin
            after_perm = 1'b0;
        end else begin
            check_eq("cmd_onehot0", 32'($countones(m_cmd) <= 1), 32'd1);
            if ((m_cmd != '0) && after_perm) begin
                check_eq("perm_wait", cyc, done_cyc + 1);
                after_perm = 1'b0;
            end
            if (m_ps) begin
                obs_rounds.push_back(32'(m_rounds));
                after_perm = 1'b1;
            end
            if (m_ab) after_perm = 1'b0;
            if (m_cmd[6]) obs_ev.push_back(EV_LD);
            if (m_cmd[5]) obs_ev.push_back(EV_IK);
            if (m_cmd[4]) obs_ev.push_back(EV_AD + 32'(m_blk));
            if (m_cmd[3]) obs_ev.push_back(EV_DS);
            if (m_cmd[2]) obs_ev.push_back(EV_DA + 32'(m_blk));
            if (m_cmd[1]) obs_ev.push_back(EV_FK);
            if (m_cmd[0]) obs_ev.push_back(EV_TG);
            if (m_done) begin
                done_cnt++;
                check_eq("done_with_tag", 32'(m_cmd[0]), 32'd1);
            end
            if (m_busy) check_eq("dec_mode", 32'(m_dec), 32'(exp_dec));
        end
    end

    function automatic void build_expected(input int unsigned n_ad, input int unsigned n_pt);
        exp_ev.delete();
        exp_rounds.delete();
        exp_ev.push_back(EV_LD);
        exp_rounds.push_back(12);
        exp_ev.push_back(EV_IK);
        for (int unsigned i = 0; i < n_ad; i++) begin
            exp_ev.push_back(EV_AD + i);
            exp_rounds.push_back(6);
        end
        exp_ev.push_back(EV_DS);
        for (int unsigned j = 0; j < n_pt; j++) begin
            exp_ev.push_back(EV_DA + j);
            if (j + 1 < n_pt) exp_rounds.push_back(6);
        end
        exp_ev.push_back(EV_FK);
        exp_rounds.push_back(12);
        exp_ev.push_back(EV_TG);
    endfunction

    task automatic run_op(input logic d, input logic poke);
        int unsigned dn0;
        int unsigned k;
        build_expected(sel ? 0 : 2, sel ? 1 : 3);
        obs_ev.delete();
        obs_rounds.delete();
        exp_dec = d;
        dn0 = done_cnt;
        start = 1'b1;
        decrypt = d;
        @(negedge clk); #1;
        start = 1'b0;
        decrypt = 1'($urandom);
        k = 0;
        while (done_cnt == dn0 && k < 400) begin
            start = poke && (k == 4);
            if (start) decrypt = ~d;
            @(negedge clk); #1;
            k++;
        end
        check_eq("op_timeout", 32'(k < 400), 32'd1);
        // currently in the TAG cycle
        if (poke) begin
            start = 1'b1;
            decrypt = ~d;
        end
        @(negedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_done", 32'(m_busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("idle_after_op", 32'(m_busy), 32'd0);
        check_eq("done_count", done_cnt, dn0 + 1);
        check_eq("dec_mode_kept", 32'(m_dec), 32'(d));
        check_eq("n_events", obs_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++)
            check_eq($sformatf("event%0d", i), obs_ev[i], exp_ev[i]);
        check_eq("n_perms", obs_rounds.size(), exp_rounds.size());
        for (int i = 0; i < exp_rounds.size() && i < obs_rounds.size(); i++)
            check_eq($sformatf("rounds%0d", i), obs_rounds[i], exp_rounds[i]);
    endtask

    task automatic abort_test();
        int unsigned k = 0;
        exp_dec = 1'b0;
        decrypt = 1'b0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        while (!(m_cmd[4] && m_blk == 8'd1) && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("abort_reach", 32'(k < 200), 32'd1);
        @(negedge clk); #1;
        check_eq("abort_adp_blk", 32'(m_blk), 32'd1);
        check_eq("abort_adp_pstart", 32'(m_ps), 32'd1);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        check_eq("aborted_pulse", 32'(m_ab), 32'd1);
        check_eq("abort_busy", 32'(m_busy), 32'd0);
        check_eq("abort_cmds", 32'(m_cmd), 32'd0);
        @(negedge clk); #1;
        check_eq("aborted_one_cycle", 32'(m_ab), 32'd0);
        check_eq("abort_blk", 32'(m_blk), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check_eq("abort_start_idle_busy", 32'(m_busy), 32'd0);
        check_eq("abort_idle_no_pulse", 32'(m_ab), 32'd0);
        repeat (6) @(negedge clk);
        #1;
        check_eq("abort_stays_idle", 32'(m_busy), 32'd0);
    endtask

    task automatic reset_test();
        int unsigned k = 0;
        exp_dec = 1'b1;
        decrypt = 1'b1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        while (!(m_cmd[2] && m_blk == 8'd0) && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("rst_reach", 32'(k < 200), 32'd1);
        @(negedge clk); #1;
        check_eq("rst_in_datp", 32'(m_ps), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        stale = 1'b1;
        check_eq("rst_outputs", 32'(m_vec), 32'd0);
        @(negedge clk); #1;
        stale = 1'b0;
        check_eq("rst_stale_done", 32'(m_vec), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check_eq("rst_stays_idle", 32'(m_vec), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0; stale = 1'b0;
        sel = 1'b0; inj = 1'b0; exp_dec = 1'b0; lat_min = 3; lat_max = 3;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outputs", 32'(m_vec), 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        run_op(1'b0, 1'b0);
        lat_min = 1;
        lat_max = 5;
        inj = 1'b1;
        run_op(1'b1, 1'b0);
        inj = 1'b0;
        run_op(1'b1, 1'b1);
        run_op(1'b0, 1'b1);
        abort_test();
        run_op(1'b0, 1'b0);
        reset_test();
        run_op(1'b1, 1'b0);

        sel = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        run_op(1'b0, 1'b0);
        inj = 1'b1;
        run_op(1'b1, 1'b1);
        inj = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
